// File: rtl/axi_mem_bist.sv
// AXI4 burst memory self-test master: writes an address-derived pattern over a DRAM region, then reads it back and compares.
// Latency: awvalid one cycle after start_i is seen; every handshake advances on the accepting edge, one transaction in flight.
// Backpressure: each valid holds with a stable payload until its ready; rready/bready are state-decoded, never gated by inputs.
module axi_mem_bist #(
    parameter int                      addr_width_p = 28,
    parameter int                      data_width_p = 64,
    parameter int                      id_width_p   = 4,
    parameter int                      burst_len_p  = 4,
    parameter int                      num_bursts_p = 256,
    parameter logic [addr_width_p-1:0] base_addr_p  = '0
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,

    output logic [id_width_p-1:0]     axi_awid_o,
    output logic [addr_width_p-1:0]   axi_awaddr_o,
    output logic [7:0]                axi_awlen_o,
    output logic [2:0]                axi_awsize_o,
    output logic [1:0]                axi_awburst_o,
    output logic [3:0]                axi_awcache_o,
    output logic [2:0]                axi_awprot_o,
    output logic                      axi_awlock_o,
    output logic                      axi_awvalid_o,
    input  logic                      axi_awready_i,

    output logic [data_width_p-1:0]   axi_wdata_o,
    output logic [data_width_p/8-1:0] axi_wstrb_o,
    output logic                      axi_wlast_o,
    output logic                      axi_wvalid_o,
    input  logic                      axi_wready_i,

    input  logic [id_width_p-1:0]     axi_bid_i,
    input  logic [1:0]                axi_bresp_i,
    input  logic                      axi_bvalid_i,
    output logic                      axi_bready_o,

    output logic [id_width_p-1:0]     axi_arid_o,
    output logic [addr_width_p-1:0]   axi_araddr_o,
    output logic [7:0]                axi_arlen_o,
    output logic [2:0]                axi_arsize_o,
    output logic [1:0]                axi_arburst_o,
    output logic [3:0]                axi_arcache_o,
    output logic [2:0]                axi_arprot_o,
    output logic                      axi_arlock_o,
    output logic                      axi_arvalid_o,
    input  logic                      axi_arready_i,

    input  logic [id_width_p-1:0]     axi_rid_i,
    input  logic [data_width_p-1:0]   axi_rdata_i,
    input  logic [1:0]                axi_rresp_i,
    input  logic                      axi_rlast_i,
    input  logic                      axi_rvalid_i,
    output logic                      axi_rready_o,

    output logic                      wr_error_o,
    output logic                      rd_error_o,
    output logic                      done_o,
    output logic [15:0]               mismatch_count_o
);

    localparam int beat_w_lp  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int burst_w_lp = (num_bursts_p > 1) ? $clog2(num_bursts_p) : 1;
    localparam logic [beat_w_lp-1:0]    last_beat_lp   = beat_w_lp'(burst_len_p - 1);
    localparam logic [burst_w_lp-1:0]   last_burst_lp  = burst_w_lp'(num_bursts_p - 1);
    localparam logic [addr_width_p-1:0] beat_bytes_lp  = addr_width_p'(8);
    localparam logic [addr_width_p-1:0] burst_bytes_lp = addr_width_p'(burst_len_p * 8);

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

    state_t                    state;
    logic [burst_w_lp-1:0]     burst_cnt;
    logic [beat_w_lp-1:0]      beat_cnt;
    logic [addr_width_p-1:0]   burst_addr;
    logic [addr_width_p-1:0]   beat_addr;
    logic [data_width_p-1:0]   wdata_r;
    logic                      awvalid_r, wvalid_r, wlast_r, bready_r, arvalid_r, rready_r;
    logic                      overrun_r;
    logic                      wr_error_r, rd_error_r, done_r;
    logic [15:0]               mismatch_r;

    logic [data_width_p-1:0]   exp_data;
    logic [data_width_p-1:0]   first_data;
    logic                      last_beat;
    logic                      beat_bad;

    function automatic logic [data_width_p-1:0] beat_pattern(input logic [addr_width_p-1:0] a);
        logic [31:0] a32;
        a32 = 32'(a);
        return {a32, ~a32};
    endfunction

    always_comb begin
        exp_data   = beat_pattern(beat_addr);
        first_data = beat_pattern(burst_addr);
        last_beat  = (beat_cnt == last_beat_lp);
        // Once a burst has overrun its length, further beats are drained without judging them.
        beat_bad   = !overrun_r && ((axi_rdata_i != exp_data) || (axi_rresp_i != 2'b00) ||
                                    (axi_rlast_i != last_beat));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            beat_cnt   <= '0;
            burst_addr <= '0;
            beat_addr  <= '0;
            wdata_r    <= '0;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            wlast_r    <= 1'b0;
            bready_r   <= 1'b0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            overrun_r  <= 1'b0;
            wr_error_r <= 1'b0;
            rd_error_r <= 1'b0;
            done_r     <= 1'b0;
            mismatch_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        burst_cnt  <= '0;
                        burst_addr <= base_addr_p;
                        awvalid_r  <= 1'b1;
                        state      <= WADDR;
                    end
                end
                WADDR: begin
                    if (axi_awready_i) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b1;
                        wdata_r   <= first_data;
                        wlast_r   <= (burst_len_p == 1);
                        beat_cnt  <= '0;
                        beat_addr <= burst_addr + beat_bytes_lp;
                        state     <= WDATA;
                    end
                end
                WDATA: begin
                    if (axi_wready_i) begin
                        if (wlast_r) begin
                            wvalid_r <= 1'b0;
                            wlast_r  <= 1'b0;
                            bready_r <= 1'b1;
                            state    <= WRESP;
                        end else begin
                            beat_cnt  <= beat_cnt + beat_w_lp'(1);
                            wdata_r   <= exp_data;
                            beat_addr <= beat_addr + beat_bytes_lp;
                            wlast_r   <= ((beat_cnt + beat_w_lp'(1)) == last_beat_lp);
                        end
                    end
                end
                WRESP: begin
                    if (axi_bvalid_i) begin
                        bready_r <= 1'b0;
                        if (axi_bresp_i != 2'b00) wr_error_r <= 1'b1;
                        if (burst_cnt == last_burst_lp) begin
                            burst_cnt  <= '0;
                            burst_addr <= base_addr_p;
                            arvalid_r  <= 1'b1;
                            state      <= RADDR;
                        end else begin
                            burst_cnt  <= burst_cnt + burst_w_lp'(1);
                            burst_addr <= burst_addr + burst_bytes_lp;
                            awvalid_r  <= 1'b1;
                            state      <= WADDR;
                        end
                    end
                end
                RADDR: begin
                    if (axi_arready_i) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        beat_cnt  <= '0;
                        beat_addr <= burst_addr;
                        overrun_r <= 1'b0;
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi_rvalid_i) begin
                        beat_cnt  <= beat_cnt + beat_w_lp'(1);
                        beat_addr <= beat_addr + beat_bytes_lp;
                        if (beat_bad) begin
                            rd_error_r <= 1'b1;
                            if (mismatch_r != 16'hFFFF) mismatch_r <= mismatch_r + 16'd1;
                        end
                        if (!overrun_r && last_beat && !axi_rlast_i) overrun_r <= 1'b1;
                        if (axi_rlast_i) begin
                            rready_r  <= 1'b0;
                            overrun_r <= 1'b0;
                            if (burst_cnt == last_burst_lp) begin
                                done_r <= 1'b1;
                                state  <= DONE;
                            end else begin
                                burst_cnt  <= burst_cnt + burst_w_lp'(1);
                                burst_addr <= burst_addr + burst_bytes_lp;
                                arvalid_r  <= 1'b1;
                                state      <= RADDR;
                            end
                        end
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Transaction IDs are never checked; only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{axi_bid_i, axi_rid_i};

    assign axi_awid_o    = '0;
    assign axi_awaddr_o  = burst_addr;
    assign axi_awlen_o   = 8'(burst_len_p - 1);
    assign axi_awsize_o  = 3'b011;
    assign axi_awburst_o = 2'b01;
    assign axi_awcache_o = 4'b0011;
    assign axi_awprot_o  = 3'b000;
    assign axi_awlock_o  = 1'b0;
    assign axi_awvalid_o = awvalid_r;

    assign axi_wdata_o   = wdata_r;
    assign axi_wstrb_o   = '1;
    assign axi_wlast_o   = wlast_r;
    assign axi_wvalid_o  = wvalid_r;
    assign axi_bready_o  = bready_r;

    assign axi_arid_o    = '0;
    assign axi_araddr_o  = burst_addr;
    assign axi_arlen_o   = 8'(burst_len_p - 1);
    assign axi_arsize_o  = 3'b011;
    assign axi_arburst_o = 2'b01;
    assign axi_arcache_o = 4'b0011;
    assign axi_arprot_o  = 3'b000;
    assign axi_arlock_o  = 1'b0;
    assign axi_arvalid_o = arvalid_r;
    assign axi_rready_o  = rready_r;

    assign wr_error_o       = wr_error_r;
    assign rd_error_o       = rd_error_r;
    assign done_o           = done_r;
    assign mismatch_count_o = mismatch_r;

endmodule

// File: tb/tb_axi_mem_bist.sv
// Bench for axi_mem_bist: two instances (plain region and wrapping region) behind one randomizable AXI slave model.
`timescale 1ns/1ps
module tb_axi_mem_bist;

    logic clk;
    logic reset_n;
    logic [1:0] start;
    logic sel;

    logic awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0] bresp, rresp;
    logic [63:0] rdata;

    logic [3:0]  awid_v[2], arid_v[2], awcache_v[2], arcache_v[2];
    logic [27:0] awaddr_v[2], araddr_v[2];
    logic [7:0]  awlen_v[2], arlen_v[2], wstrb_v[2];
    logic [2:0]  awsize_v[2], arsize_v[2], awprot_v[2], arprot_v[2];
    logic [1:0]  awburst_v[2], arburst_v[2];
    logic        awlock_v[2], arlock_v[2], awvalid_v[2], arvalid_v[2];
    logic        wlast_v[2], wvalid_v[2], bready_v[2], rready_v[2];
    logic        wr_err_v[2], rd_err_v[2], done_v[2];
    logic [63:0] wdata_v[2];
    logic [15:0] cnt_v[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_mem_bist #(
            .addr_width_p(28), .data_width_p(64), .id_width_p(4), .burst_len_p(4),
            .num_bursts_p(g == 0 ? 4 : 2),
            .base_addr_p(g == 0 ? 28'h0000000 : 28'hFFFFFE0)
        ) dut (
            .clk_i(clk), .reset_n_i(reset_n), .start_i(start[g]),
            .axi_awid_o(awid_v[g]), .axi_awaddr_o(awaddr_v[g]), .axi_awlen_o(awlen_v[g]),
            .axi_awsize_o(awsize_v[g]), .axi_awburst_o(awburst_v[g]), .axi_awcache_o(awcache_v[g]),
            .axi_awprot_o(awprot_v[g]), .axi_awlock_o(awlock_v[g]), .axi_awvalid_o(awvalid_v[g]),
            .axi_awready_i(awready),
            .axi_wdata_o(wdata_v[g]), .axi_wstrb_o(wstrb_v[g]), .axi_wlast_o(wlast_v[g]),
            .axi_wvalid_o(wvalid_v[g]), .axi_wready_i(wready),
            .axi_bid_i(4'd0), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready_v[g]),
            .axi_arid_o(arid_v[g]), .axi_araddr_o(araddr_v[g]), .axi_arlen_o(arlen_v[g]),
            .axi_arsize_o(arsize_v[g]), .axi_arburst_o(arburst_v[g]), .axi_arcache_o(arcache_v[g]),
            .axi_arprot_o(arprot_v[g]), .axi_arlock_o(arlock_v[g]), .axi_arvalid_o(arvalid_v[g]),
            .axi_arready_i(arready),
            .axi_rid_i(4'd0), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
            .axi_rvalid_i(rvalid), .axi_rready_o(rready_v[g]),
            .wr_error_o(wr_err_v[g]), .rd_error_o(rd_err_v[g]), .done_o(done_v[g]),
            .mismatch_count_o(cnt_v[g])
        );
    end

    logic        m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
    logic        m_wr_err, m_rd_err, m_done;
    logic [27:0] m_awaddr, m_araddr;
    logic [7:0]  m_awlen, m_arlen, m_wstrb;
    logic [63:0] m_wdata;
    logic [15:0] m_cnt;
    assign m_awvalid = awvalid_v[sel];
    assign m_wvalid  = wvalid_v[sel];
    assign m_wlast   = wlast_v[sel];
    assign m_bready  = bready_v[sel];
    assign m_arvalid = arvalid_v[sel];
    assign m_rready  = rready_v[sel];
    assign m_wr_err  = wr_err_v[sel];
    assign m_rd_err  = rd_err_v[sel];
    assign m_done    = done_v[sel];
    assign m_awaddr  = awaddr_v[sel];
    assign m_araddr  = araddr_v[sel];
    assign m_awlen   = awlen_v[sel];
    assign m_arlen   = arlen_v[sel];
    assign m_wstrb   = wstrb_v[sel];
    assign m_wdata   = wdata_v[sel];
    assign m_cnt     = cnt_v[sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit abort;
    int flip_beat, bresp_burst, early_burst, missing_burst;
    int wr_beats;
    logic [63:0] first_wdata;
    logic [63:0] mem [logic [27:0]];

    // Reference beat content: the byte address zero-extended to 32 bits, followed by its complement.
    function automatic logic [63:0] pat(input logic [27:0] a);
        logic [31:0] z;
        z = {4'h0, a};
        return {z, ~z};
    endfunction

    task automatic clear_slave();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
    endtask

    task automatic timeout(input string what);
        errors++;
        abort = 1;
        $display("FAIL timeout_%s: no handshake within 200 cycles, required one", what);
    endtask

    task automatic step_aw(input logic [27:0] exp_addr, input bit rnd);
        int t = 0;
        if (abort) return;
        forever begin
            @(negedge clk); clear_slave();
            awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_awvalid && awready) break;
            t++;
            if (t > 200) begin timeout("aw"); return; end
        end
        checks++;
        if (m_awaddr !== exp_addr || m_awlen !== 8'd3) begin
            errors++;
            $display("FAIL aw_addr: got %h len %0d, required %h len 3", m_awaddr, m_awlen, exp_addr);
        end
    endtask

    task automatic step_w(input logic [27:0] a, input bit last, input bit rnd);
        int t = 0;
        if (abort) return;
        forever begin
            @(negedge clk); clear_slave();
            wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_wvalid && wready) break;
            t++;
            if (t > 200) begin timeout("w"); return; end
        end
        if (wr_beats == 0) first_wdata = m_wdata;
        wr_beats++;
        mem[a] = m_wdata;
        checks++;
        if (m_wdata !== pat(a) || m_wlast !== last || m_wstrb !== 8'hFF) begin
            errors++;
            $display("FAIL w_beat @%h: got %h last %0b strb %h, required %h last %0b strb ff",
                     a, m_wdata, m_wlast, m_wstrb, pat(a), last);
        end
    endtask

    task automatic step_b(input logic [1:0] resp, input bit rnd);
        int t = 0;
        int gap = rnd ? int'($urandom_range(0, 2)) : 0;
        if (abort) return;
        forever begin
            @(negedge clk); clear_slave();
            if (gap > 0) gap--;
            else begin
                bvalid = 1; bresp = resp;
                if (m_bready) break;
            end
            t++;
            if (t > 200) begin timeout("b"); return; end
        end
    endtask

    task automatic step_ar(input logic [27:0] exp_addr, input bit rnd);
        int t = 0;
        if (abort) return;
        forever begin
            @(negedge clk); clear_slave();
            arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_arvalid && arready) break;
            t++;
            if (t > 200) begin timeout("ar"); return; end
        end
        checks++;
        if (m_araddr !== exp_addr || m_arlen !== 8'd3) begin
            errors++;
            $display("FAIL ar_addr: got %h len %0d, required %h len 3", m_araddr, m_arlen, exp_addr);
        end
    endtask

    task automatic step_r(input logic [63:0] d, input bit last, input bit rnd);
        int t = 0;
        int gap = rnd ? int'($urandom_range(0, 2)) : 0;
        if (abort) return;
        forever begin
            @(negedge clk); clear_slave();
            if (gap > 0) gap--;
            else begin
                rvalid = 1; rdata = d; rlast = last;
                if (m_rready) break;
            end
            t++;
            if (t > 200) begin timeout("r"); return; end
        end
    endtask

    // Slave model: accepts the whole write phase into mem, then replays mem with the configured faults.
    task automatic run_slave(input int nb, input logic [27:0] base, input bit rnd);
        logic [27:0] ba;
        logic [63:0] d;
        int n;
        mem.delete();
        wr_beats = 0;
        for (int k = 0; k < nb; k++) begin
            ba = base + 28'(k * 32);
            step_aw(ba, rnd);
            for (int i = 0; i < 4; i++) step_w(ba + 28'(8 * i), i == 3, rnd);
            step_b((k == bresp_burst) ? 2'b10 : 2'b00, rnd);
        end
        for (int k = 0; k < nb; k++) begin
            ba = base + 28'(k * 32);
            step_ar(ba, rnd);
            n = (k == early_burst) ? 2 : (k == missing_burst) ? 6 : 4;
            for (int i = 0; i < n; i++) begin
                d = (i < 4 && mem.exists(ba + 28'(8 * i))) ? mem[ba + 28'(8 * i)] : {$urandom, $urandom};
                if (k * 4 + i == flip_beat) d = d ^ 64'd1;
                step_r(d, i == n - 1, rnd);
            end
        end
        @(negedge clk); clear_slave();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; start = 2'b00; clear_slave();
        abort = 0; flip_beat = -1; bresp_burst = -1; early_burst = -1; missing_burst = -1;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic kick(input bit which);
        sel = which;
        @(negedge clk);
        start[which] = 1'b1;
        @(negedge clk);
        checks++;
        if (m_awvalid !== 1'b1) begin
            errors++;
            $display("FAIL start_to_awvalid: got %0b, required 1 one cycle after start", m_awvalid);
        end
    endtask

    task automatic test_reset();
        reset_n = 0; start = 2'b00; sel = 0; clear_slave();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({awvalid_v[s], wvalid_v[s], wlast_v[s], bready_v[s], arvalid_v[s], rready_v[s],
                 done_v[s], wr_err_v[s], rd_err_v[s]} !== 9'd0) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got %b, required 0", s,
                         {awvalid_v[s], wvalid_v[s], wlast_v[s], bready_v[s], arvalid_v[s],
                          rready_v[s], done_v[s], wr_err_v[s], rd_err_v[s]});
            end
            checks++;
            if (cnt_v[s] !== 16'd0 || awaddr_v[s] !== 28'd0 || wdata_v[s] !== 64'd0) begin
                errors++;
                $display("FAIL reset_regs[%0d]: got cnt %h addr %h data %h, required 0", s,
                         cnt_v[s], awaddr_v[s], wdata_v[s]);
            end
            checks++;
            if ({awsize_v[s], awburst_v[s], awcache_v[s], awprot_v[s], awlock_v[s], awid_v[s], awlen_v[s]} !==
                {3'b011, 2'b01, 4'b0011, 3'b000, 1'b0, 4'd0, 8'd3} ||
                {arsize_v[s], arburst_v[s], arcache_v[s], arprot_v[s], arlock_v[s], arid_v[s], arlen_v[s]} !==
                {3'b011, 2'b01, 4'b0011, 3'b000, 1'b0, 4'd0, 8'd3} || wstrb_v[s] !== 8'hFF) begin
                errors++;
                $display("FAIL reset_consts[%0d]: aw %h ar %h strb %h differ from size3/incr/cache3/len3", s,
                         {awsize_v[s], awburst_v[s], awcache_v[s], awprot_v[s], awlock_v[s], awid_v[s], awlen_v[s]},
                         {arsize_v[s], arburst_v[s], arcache_v[s], arprot_v[s], arlock_v[s], arid_v[s], arlen_v[s]},
                         wstrb_v[s]);
            end
        end
    endtask

    task automatic test_clean();
        do_reset();
        kick(0);
        run_slave(4, 28'h0, 0);
        checks++;
        if (wr_beats !== 16 || first_wdata !== 64'h00000000_FFFFFFFF) begin
            errors++;
            $display("FAIL clean_writes: got %0d beats first %h, required 16 and 00000000ffffffff",
                     wr_beats, first_wdata);
        end
        checks++;
        if ({m_done, m_wr_err, m_rd_err} !== 3'b100 || m_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clean_status: got done/wr/rd %b cnt %0d, required 100 cnt 0",
                     {m_done, m_wr_err, m_rd_err}, m_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (m_awvalid !== 1'b0 || m_done !== 1'b1) begin
            errors++;
            $display("FAIL clean_terminal: got awvalid %0b done %0b with start held, required 0 1",
                     m_awvalid, m_done);
        end
    endtask

    task automatic test_corrupt();
        do_reset();
        flip_beat = 5;
        kick(0);
        run_slave(4, 28'h0, 0);
        checks++;
        if ({m_done, m_wr_err, m_rd_err} !== 3'b101 || m_cnt !== 16'd1) begin
            errors++;
            $display("FAIL corrupt_status: got done/wr/rd %b cnt %0d, required 101 cnt 1",
                     {m_done, m_wr_err, m_rd_err}, m_cnt);
        end
    endtask

    task automatic test_bresp_error();
        do_reset();
        bresp_burst = 2;
        kick(0);
        run_slave(4, 28'h0, 0);
        checks++;
        if ({m_done, m_wr_err, m_rd_err} !== 3'b110 || m_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bresp_status: got done/wr/rd %b cnt %0d, required 110 cnt 0",
                     {m_done, m_wr_err, m_rd_err}, m_cnt);
        end
    endtask

    task automatic test_early_rlast();
        do_reset();
        early_burst = 0;
        kick(0);
        run_slave(4, 28'h0, 0);
        checks++;
        if ({m_done, m_wr_err, m_rd_err} !== 3'b101 || m_cnt !== 16'd1) begin
            errors++;
            $display("FAIL early_rlast_status: got done/wr/rd %b cnt %0d, required 101 cnt 1",
                     {m_done, m_wr_err, m_rd_err}, m_cnt);
        end
    endtask

    task automatic test_missing_rlast();
        do_reset();
        missing_burst = 1;
        kick(0);
        run_slave(4, 28'h0, 0);
        checks++;
        if ({m_done, m_wr_err, m_rd_err} !== 3'b101 || m_cnt !== 16'd1) begin
            errors++;
            $display("FAIL missing_rlast_status: got done/wr/rd %b cnt %0d, required 101 cnt 1",
                     {m_done, m_wr_err, m_rd_err}, m_cnt);
        end
    endtask

    task automatic test_backpressure_wrap();
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            kick(1);
            run_slave(2, 28'hFFFFFE0, 1);
            checks++;
            if ({m_done, m_wr_err, m_rd_err} !== 3'b100 || m_cnt !== 16'd0 || wr_beats !== 8) begin
                errors++;
                $display("FAIL wrap_status[%0d]: got done/wr/rd %b cnt %0d beats %0d, required 100 cnt 0 beats 8",
                         rep, {m_done, m_wr_err, m_rd_err}, m_cnt, wr_beats);
            end
        end
        sel = 0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        kick(0);
        step_aw(28'h0, 0);
        step_w(28'h0, 0, 0);
        step_w(28'h8, 0, 0);
        @(negedge clk);
        clear_slave();
        reset_n = 0;
        start = 2'b00;
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready, m_done, m_wr_err, m_rd_err} !== 9'd0 ||
            m_cnt !== 16'd0 || m_awaddr !== 28'd0 || m_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got flags %b cnt %h addr %h data %h, required all 0",
                     {m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready, m_done, m_wr_err, m_rd_err},
                     m_cnt, m_awaddr, m_wdata);
        end
        reset_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: got awvalid %0b wvalid %0b without start, required 0 0",
                     m_awvalid, m_wvalid);
        end
        abort = 0;
        kick(0);
        run_slave(4, 28'h0, 0);
        checks++;
        if ({m_done, m_wr_err, m_rd_err} !== 3'b100 || m_cnt !== 16'd0 || wr_beats !== 16) begin
            errors++;
            $display("FAIL reset_mid_rerun: got done/wr/rd %b cnt %0d beats %0d, required 100 cnt 0 beats 16",
                     {m_done, m_wr_err, m_rd_err}, m_cnt, wr_beats);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_corrupt();
        test_bresp_error();
        test_early_rlast();
        test_missing_rlast();
        test_backpressure_wrap();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
